player_hit_flash: RTL and testbench

Generates the `invert_player` control consumed by the player colour-inversion stage. On a hit it produces a frame-synchronous blink, alternating white-inverted and normal sprite for a configurable number of frames, and flags the player invulnerable for that window. On death it forces solid inversion. It sits between the collision/game-logic block and the player sprite pipeline.

---
 rtl/player_hit_flash.sv | 123 ++++++++++++
 tb/tb_player_hit_flash.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/player_hit_flash.sv
// Player hit-flash controller: frame-synchronous blink and invulnerability after a hit, solid inversion on death.
// Optional feature macro: PLAYER_FLASH_RETRIGGER_EN (a hit during a flash restarts it).
module player_hit_flash #(
    parameter int unsigned FLASH_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic hit,
    input  logic dead,
    output logic invert_player,
    output logic invulnerable,
    output logic flash_done
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES);
    localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef PLAYER_FLASH_RETRIGGER_EN
    localparam bit RETRIGGER_EN = 1'b1;
`else
    localparam bit RETRIGGER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLASH = 2'd1,
        S_DEAD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic             invert_q, invert_d;
    logic             invuln_q, invuln_d;
    logic             done_q, done_d;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            invert_q    <= 1'b0;
            invuln_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            invert_q    <= invert_d;
            invuln_q    <= invuln_d;
            done_q      <= done_d;
        end
    end

    // Next-state: dead beats hit, hit beats startOfFrame
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        done_d      = 1'b0;

        if (dead) begin
            state_d = S_DEAD;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        state_d     = S_FLASH;
                        frame_cnt_d = FLASH_LOAD;
                        blink_cnt_d = BLINK_LOAD;
                        phase_d     = 1'b1;
                    end
                end
                S_FLASH: begin
                    if (RETRIGGER_EN && hit) begin
                        frame_cnt_d = FLASH_LOAD;
                        blink_cnt_d = BLINK_LOAD;
                        phase_d     = 1'b1;
                    end else if (startOfFrame) begin
                        if (frame_cnt_q == CNT_ONE) begin
                            state_d     = S_IDLE;
                            frame_cnt_d = '0;
                            blink_cnt_d = '0;
                            phase_d     = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q - CNT_ONE;
                            if (blink_cnt_q == CNT_ONE) begin
                                blink_cnt_d = BLINK_LOAD;
                                phase_d     = ~phase_q;
                            end else begin
                                blink_cnt_d = blink_cnt_q - CNT_ONE;
                            end
                        end
                    end
                end
                S_DEAD: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they move with it
        invert_d = ((state_d == S_FLASH) && phase_d) || (state_d == S_DEAD);
        invuln_d = (state_d == S_FLASH) || (state_d == S_DEAD);
    end

    assign invert_player = invert_q;
    assign invulnerable  = invuln_q;
    assign flash_done    = done_q;

endmodule

// File: tb/tb_player_hit_flash.sv
// Scoreboard bench for player_hit_flash with FLASH_FRAMES=6, BLINK_FRAMES=2.
module tb_player_hit_flash;

    typedef struct packed {
        int   id;
        logic inv;
        logic invul;
        logic done;
    } exp_t;

    logic clk;
    logic reset;
    logic startOfFrame;
    logic hit;
    logic dead;
    logic invert_player;
    logic invulnerable;
    logic flash_done;

    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;
    exp_t exp_q[$];

    player_hit_flash #(
        .FLASH_FRAMES(6),
        .BLINK_FRAMES(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .hit          (hit),
        .dead         (dead),
        .invert_player(invert_player),
        .invulnerable (invulnerable),
        .flash_done   (flash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step=%0d got=%b want=%b", name, id, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input logic h, input logic s, input logic d,
                        input logic ei, input logic ev, input logic ed);
        exp_t e;
        @(negedge clk);
        hit          = h;
        startOfFrame = s;
        dead         = d;
        seq++;
        e.id    = seq;
        e.inv   = ei;
        e.invul = ev;
        e.done  = ed;
        exp_q.push_back(e);
    endtask

    // n SOF pulses, each followed by a quiet cycle; pat[k] = invert after SOF k+1
    task automatic flash_run(input int n, input logic [15:0] pat, input bit ends);
        logic inv_e;
        logic last;
        for (int k = 0; k < n; k++) begin
            last  = ends && (k == n - 1);
            inv_e = last ? 1'b0 : pat[k];
            step(1'b0, 1'b1, 1'b0, inv_e, ~last, last);
            step(1'b0, 1'b0, 1'b0, inv_e, ~last, 1'b0);
        end
    endtask

    // Assert reset mid-cycle and confirm outputs clear before the next edge
    task automatic do_reset(input string name);
        @(negedge clk);
        hit          = 1'b0;
        startOfFrame = 1'b0;
        dead         = 1'b0;
        reset        = 1'b1;
        #1;
        chk({name, "_inv"},   seq, invert_player, 1'b0);
        chk({name, "_invul"}, seq, invulnerable,  1'b0);
        chk({name, "_done"},  seq, flash_done,    1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents a fresh output set
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("invert_player", e.id, invert_player, e.inv);
                chk("invulnerable",  e.id, invulnerable,  e.invul);
                chk("flash_done",    e.id, flash_done,    e.done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        hit          = 1'b0;
        startOfFrame = 1'b0;
        dead         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_inv",   0, invert_player, 1'b0);
        chk("rst_invul", 0, invulnerable,  1'b0);
        chk("rst_done",  0, flash_done,    1'b0);
        reset = 1'b0;

        // Idle after reset, including a stray SOF
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic flash: inverted, normal after SOF2, inverted after SOF4, done at SOF6
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        flash_run(6, 16'b011001, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Re-hit after SOF3
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        flash_run(3, 16'b001, 1'b0);
`ifdef PLAYER_FLASH_RETRIGGER_EN
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        flash_run(6, 16'b011001, 1'b1);
`else
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        flash_run(3, 16'b011, 1'b1);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Same-cycle hit and SOF in idle: that frame does not count
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        flash_run(6, 16'b011001, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Death after SOF1: solid inversion, hits ignored, only reset leaves
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        flash_run(1, 16'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        flash_run(10, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        do_reset("dead_rst");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-flash after SOF3, then a fresh full flash
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        flash_run(3, 16'b001, 1'b0);
        do_reset("mid_rst");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        flash_run(6, 16'b011001, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        hit          = 1'b0;
        startOfFrame = 1'b0;
        dead         = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", seq, exp_q.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
